// File: rtl/int_to_float_converter_if.sv
// Handshake bundle for the integer-to-float converter: one request channel in, one result out.
interface int_to_float_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_value;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_value;
  logic        inexact;

  modport slave (
    input  in_valid, int_value, is_signed, out_ready,
    output in_ready, out_valid, float_value, inexact
  );

  modport master (
    output in_valid, int_value, is_signed, out_ready,
    input  in_ready, out_valid, float_value, inexact
  );
endinterface

// File: rtl/int_to_float_converter.sv
// Sequential 32-bit integer to IEEE-754 binary32 converter: normalises one bit per cycle,
// then rounds to nearest-even.
module int_to_float_converter (
  input  logic                          clk,
  input  logic                          rst_n,
  int_to_float_converter_if.slave       bus
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  // Bit 31 of the magnitude is implicit: it only steers IDLE, and after
  // normalisation it is the hidden leading one.
  logic [30:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] float_q, float_d;
  logic        inexact_q, inexact_d;

  logic        sign_in;
  logic [31:0] mag_in;
  logic        guard, sticky, round_up;
  logic [23:0] frac_rnd;
  logic [7:0]  exp_rnd;

  assign sign_in  = bus.is_signed & bus.int_value[31];
  assign mag_in   = sign_in ? (~bus.int_value + 32'd1) : bus.int_value;

  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign round_up = guard & (sticky | mag_q[8]);
  assign frac_rnd = {1'b0, mag_q[30:8]} + {23'd0, round_up};
  assign exp_rnd  = exp_q + {7'd0, frac_rnd[23]};

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    float_d   = float_q;
    inexact_d = inexact_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d = sign_in;
          mag_d  = mag_in[30:0];
          exp_d  = 8'd158;
          if (mag_in == 32'd0) begin
            float_d   = 32'd0;
            inexact_d = 1'b0;
            state_d   = StDone;
          end else if (mag_in[31]) begin
            state_d = StRound;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        mag_d = {mag_q[29:0], 1'b0};
        exp_d = exp_q - 8'd1;
        if (mag_q[30]) state_d = StRound;
      end
      StRound: begin
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        float_d   = {sign_q, exp_rnd, frac_rnd[22:0]};
        inexact_d = guard | sticky;
        state_d   = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      float_q   <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      float_q   <= float_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.float_value = float_q;
  assign bus.inexact     = inexact_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Scoreboard bench for int_to_float_converter: directed corner cases plus random operands.
module tb_int_to_float_converter;

  logic clk;
  logic rst_n;

  int_to_float_converter_if bus ();

  int_to_float_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fval;
    logic        ix;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference conversion by explicit leading-one search and remainder comparison.
  function automatic void model(input logic [31:0] v, input logic s,
                                output logic [31:0] f, output logic ix, output int lat);
    logic        sg;
    logic [63:0] m, kept, rem, half;
    int          p, sh;
    sg = s & v[31];
    m  = sg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    if (m == 64'd0) begin
      f = 32'd0; ix = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = (31 - p) + 2;
    if (p <= 23) begin
      kept = m << (23 - p);
      ix   = 1'b0;
    end else begin
      sh   = p - 23;
      kept = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      ix = (rem != 64'd0);
      if (kept[24]) begin
        kept = kept >> 1;
        p++;
      end
    end
    f = {sg, 8'(127 + p), kept[22:0]};
  endfunction

  // Drive one operand, push its expectation, wait for the result, optionally stall the consumer.
  task automatic convert(input string tag, input logic [31:0] v, input logic s,
                         input logic [31:0] want_f, input logic want_ix, input int want_lat,
                         input int hold);
    exp_t        e;
    exp_t        got_e;
    int          lat;
    logic [31:0] f0;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.int_value = v;
    bus.is_signed = s;
    @(posedge clk);
    e.fval = want_f; e.ix = want_ix; e.lat = want_lat;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.int_value = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check_eq({tag, ".timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    got_e = exp_q.pop_front();
    check_eq({tag, ".float"}, bus.float_value, got_e.fval);
    check_eq({tag, ".inexact"}, 32'(bus.inexact), 32'(got_e.ix));
    check_eq({tag, ".latency"}, 32'(lat), 32'(got_e.lat));
    f0 = bus.float_value;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = 1'b1;
      bus.int_value = $urandom;
      bus.is_signed = 1'($urandom);
      @(negedge clk);
      check_eq({tag, ".hold_float"}, bus.float_value, f0);
      check_eq({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      check_eq({tag, ".hold_out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, ".post_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic convert_model(input string tag, input logic [31:0] v, input logic s);
    logic [31:0] f;
    logic        ix;
    int          lat;
    model(v, s, f, ix, lat);
    convert(tag, v, s, f, ix, lat, 0);
  endtask

  initial begin
    logic saw_valid;
    logic [31:0] rv;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.int_value = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst.float", bus.float_value, 32'd0);
    check_eq("rst.inexact", 32'(bus.inexact), 32'd0);
    rst_n = 1'b1;

    convert("zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1, 0);
    convert("u1", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 33, 0);
    convert("sm1", 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 33, 0);
    convert("smin", 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 2, 0);
    convert("umax", 32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 2, 0);
    convert("tie_even", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 9, 0);
    convert("tie_up", 32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 9, 0);
    convert("stall", 32'h0000_0064, 1'b0, 32'h42C8_0000, 1'b0, 27, 5);

    // Reset during normalisation of value 1 must discard the result.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.int_value = 32'h0000_0001;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort.pre_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort.out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check_eq("abort.no_result", 32'(saw_valid), 32'd0);
    check_eq("abort.idle", 32'(bus.in_ready), 32'd1);

    convert("after_rst", 32'd100, 1'b0, 32'h42C8_0000, 1'b0, 27, 0);

    for (int i = 0; i < 12; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      convert_model($sformatf("rnd%0d", i), rv, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_float_converter.md
# int_to_float_converter

Sequential integer-to-IEEE-754 single-precision converter. It is the reverse-direction counterpart of the ALU's float-to-integer conversion (operation 9). It accepts a 32-bit signed or unsigned integer over a valid/ready handshake and normalises iteratively, one bit per cycle. It rounds to nearest-even and returns the float over a second valid/ready handshake. It sits beside the ALU and feeds its floating-point operand paths.

## Interface
- No parameters; widths fixed at 32-bit integer in, IEEE-754 binary32 out.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `int_value`/`is_signed` valid.
- `in_ready` output 1: converter idle, can accept.
- `int_value` input 32: integer operand.
- `is_signed` input 1: 1 = two's-complement, 0 = unsigned.
- `out_valid` output 1: `float_value`/`inexact` valid.
- `out_ready` input 1: consumer accepts result.
- `float_value` output 32: IEEE-754 result {sign, exp[7:0], frac[22:0]}.
- `inexact` output 1: result was rounded (dropped bits non-zero).

## Operation
- States:
  - IDLE: `in_ready`=1.
  - NORM: shift.
  - ROUND.
  - DONE: `out_valid`=1.
- Accept on `in_valid & in_ready`. The following are registered at this edge:
  - sign = `is_signed & int_value[31]`.
  - mag = sign ? (~int_value + 1) : int_value, 32-bit unsigned. 0x80000000 signed gives mag 0x80000000.
  - exp = 158 (127+31).
- Next state from IDLE on accept:
  - mag==0 → DONE with result 0x00000000, inexact=0.
  - mag[31]==1 → ROUND.
  - Otherwise → NORM.
- NORM, each cycle: mag <= mag<<1, exp <= exp−1. Go to ROUND when the pre-shift mag[30]==1. NORM occupies exactly lz(mag) cycles, 1..31.
- ROUND, one cycle:
  - frac = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Increment when guard & (sticky | mag[8]).
  - If frac carries out (all ones + 1): frac=0, exp+1.
  - inexact = guard | sticky.
  - Result = {sign, exp, frac}. Next state DONE.
- Exponent never overflows; maximum result exponent is 159 (2^32). Denormals, NaN and Inf are never produced.
- DONE: hold `float_value`/`inexact` stable until `out_valid & out_ready`, then go to IDLE.
- Inputs are ignored while `in_ready`=0. `int_value` need not be held after acceptance.

## Timing
- Reset (asynchronous assert, synchronous deassert via `clk`):
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `float_value`=0, `inexact`=0.
  - All internal registers cleared.
- Reset mid-conversion aborts immediately. The in-flight result is discarded and never presented.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency, from accept edge to first cycle with `out_valid`=1:
  - Zero input: 1 cycle.
  - Nonzero: lz+2 cycles. Minimum 2 (bit 31 set), maximum 33 (value 1).
- Throughput: one conversion in flight.
  - `in_ready` rises the cycle after the output handshake completes.
  - No same-cycle output-accept/input-accept overlap.
- Backpressure: `out_ready` low holds DONE indefinitely with outputs stable.

## Test plan
- Reset values and zero input:
  - Check reset outputs.
  - Signed 0 → 0x00000000, inexact 0, `out_valid` 1 cycle after accept.
- Minimum magnitude:
  - Unsigned 1 → 0x3F800000, inexact 0, latency 33.
  - Signed −1 (0xFFFFFFFF) → 0xBF800000, latency 33.
- Most-negative input: signed 0x80000000 → 0xCF000000, inexact 0, latency 2.
- Round-up carry into exponent: unsigned 0xFFFFFFFF → 0x4F800000, inexact 1.
- Tie rounding:
  - 16777217 (0x01000001) → 0x4B800000 (tie, even kept), inexact 1.
  - 16777219 (0x01000003) → 0x4B800002 (tie, rounds up to even), inexact 1.
- Handshake and reset:
  - Hold `out_ready`=0 for 5 cycles: `float_value` stable, `in_ready`=0, `in_valid` pulses ignored.
  - Assert `rst_n` low during NORM of value 1: `out_valid` stays 0, `in_ready`=1 after release.
  - Next conversion (100 → 0x42C80000) is correct.
